uart_bus_sequencer: RTL and testbench

- Sole bus master for the UART register block's wr/rd/addr/din/dout interface.
- After reset, or on `start_i`, it runs the fixed programming sequence: LCR with DLAB set, DLL, DLM, LCR with DLAB cleared, FCR.
- Once configured, it round-robin arbitrates between a TX-byte requester and a generic host register-access requester.
- It hides the register block's read latency behind a req/ack handshake.

---
 rtl/uart_bus_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_uart_bus_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_sequencer.sv
// Bus master for the UART register block: programs LCR/DLL/DLM/LCR/FCR after reset or start_i,
// then round-robins TX-byte and host register accesses. Optional readback check: UART_CFG_READBACK_EN.
module uart_bus_sequencer #(
  parameter logic [15:0] DIV_DEFAULT = 16'h0108,
  parameter logic [7:0]  LCR_DEFAULT = 8'h03,
  parameter logic [7:0]  FCR_DEFAULT = 8'h07,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] div_i,
  input  logic [7:0]  lcr_i,
  input  logic [7:0]  fcr_i,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        cfg_err_o,
  input  logic        tx_req_i,
  input  logic [7:0]  tx_data_i,
  output logic        tx_ack_o,
  input  logic        host_req_i,
  input  logic        host_we_i,
  input  logic [2:0]  host_addr_i,
  input  logic [7:0]  host_wdata_i,
  output logic        host_ack_o,
  output logic [7:0]  host_rdata_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic [2:0]  addr_o,
  output logic [7:0]  din_o,
  input  logic [7:0]  dout_i
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic GNT_TX   = 1'b0;
  localparam logic GNT_HOST = 1'b1;

`ifdef UART_CFG_READBACK_EN
  typedef enum logic [2:0] {C_LCR1, C_DLL, C_DLM, C_LCR2, C_FCR, READY, RD_WAIT, RB_WAIT} state_t;
`else
  typedef enum logic [2:0] {C_LCR1, C_DLL, C_DLM, C_LCR2, C_FCR, READY, RD_WAIT} state_t;
`endif

  state_t           state_q;
  logic [15:0]      div_q;
  logic [7:0]       lcr_q;
  logic [7:0]       fcr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic             start_pend_q;
  logic             cfg_done_q, busy_q, cfg_err_q;
  logic             tx_ack_q, host_ack_q, wr_q, rd_q;
  logic [7:0]       host_rdata_q, din_q;
  logic [2:0]       addr_q;

  // Single-process FSM; strobes and acks default low every cycle, addr/din hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_LCR1;
      div_q        <= DIV_DEFAULT;
      lcr_q        <= LCR_DEFAULT;
      fcr_q        <= FCR_DEFAULT;
      cnt_q        <= '0;
      last_grant_q <= GNT_HOST;
      start_pend_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      tx_ack_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= 3'd0;
      din_q        <= 8'h00;
    end else begin
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      tx_ack_q   <= 1'b0;
      host_ack_q <= 1'b0;
      busy_q     <= 1'b1;
      if (start_i) begin
        div_q      <= div_i;
        lcr_q      <= lcr_i;
        fcr_q      <= fcr_i;
        cfg_done_q <= 1'b0;
        cfg_err_q  <= 1'b0;
      end
      if (start_i && (state_q != RD_WAIT)) begin
        state_q <= C_LCR1;
      end else begin
        if (start_i) start_pend_q <= 1'b1;
        case (state_q)
          C_LCR1: begin
            wr_q <= 1'b1; addr_q <= 3'd3; din_q <= lcr_q | 8'h80; state_q <= C_DLL;
          end
          C_DLL: begin
            wr_q <= 1'b1; addr_q <= 3'd0; din_q <= div_q[7:0]; state_q <= C_DLM;
          end
          C_DLM: begin
            wr_q <= 1'b1; addr_q <= 3'd1; din_q <= div_q[15:8]; state_q <= C_LCR2;
          end
          C_LCR2: begin
            wr_q <= 1'b1; addr_q <= 3'd3; din_q <= lcr_q & 8'h7F; state_q <= C_FCR;
          end
          C_FCR: begin
            wr_q <= 1'b1; addr_q <= 3'd2; din_q <= fcr_q;
`ifdef UART_CFG_READBACK_EN
            cnt_q   <= '0;
            state_q <= RB_WAIT;
`else
            busy_q  <= 1'b0;
            state_q <= READY;
`endif
          end
          READY: begin
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b1;
            // On a tie, grant whichever requester was not served last.
            if (tx_req_i && (!host_req_i || (last_grant_q == GNT_HOST))) begin
              wr_q         <= 1'b1;
              addr_q       <= 3'd0;
              din_q        <= tx_data_i;
              tx_ack_q     <= 1'b1;
              last_grant_q <= GNT_TX;
            end else if (host_req_i) begin
              last_grant_q <= GNT_HOST;
              addr_q       <= host_addr_i;
              if (host_we_i) begin
                wr_q       <= 1'b1;
                din_q      <= (host_addr_i == 3'd3) ? (host_wdata_i & 8'h7F) : host_wdata_i;
                host_ack_q <= 1'b1;
              end else begin
                rd_q    <= 1'b1;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            if (cnt_q == RD_LAT_C) begin
              host_rdata_q <= dout_i;
              host_ack_q   <= 1'b1;
              start_pend_q <= 1'b0;
              if (start_pend_q || start_i) begin
                state_q <= C_LCR1;
              end else begin
                busy_q  <= 1'b0;
                state_q <= READY;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`ifdef UART_CFG_READBACK_EN
          RB_WAIT: begin
            // cnt 0 issues the LCR read; data is valid RD_LAT cycles after the strobe.
            if (cnt_q == '0) begin
              rd_q   <= 1'b1;
              addr_q <= 3'd3;
              cnt_q  <= cnt_q + CNT_W'(1);
            end else if (cnt_q == (RD_LAT_C + CNT_W'(1))) begin
              if (dout_i != (lcr_q & 8'h7F)) cfg_err_q <= 1'b1;
              cfg_done_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= READY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
`endif
          default: state_q <= C_LCR1;
        endcase
      end
    end
  end

  assign cfg_done_o   = cfg_done_q;
  assign busy_o       = busy_q;
  assign cfg_err_o    = cfg_err_q;
  assign tx_ack_o     = tx_ack_q;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;
  assign wr_o         = wr_q;
  assign rd_o         = rd_q;
  assign addr_o       = addr_q;
  assign din_o        = din_q;

endmodule

// File: tb/tb_uart_bus_sequencer.sv
// Directed self-checking bench for uart_bus_sequencer (default build, RD_LAT = 2).
module tb_uart_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] div_i = 16'h0;
  logic [7:0]  lcr_i = 8'h0;
  logic [7:0]  fcr_i = 8'h0;
  logic        cfg_done_o, busy_o, cfg_err_o;
  logic        tx_req_i = 1'b0;
  logic [7:0]  tx_data_i = 8'h0;
  logic        tx_ack_o;
  logic        host_req_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [2:0]  host_addr_i = 3'd0;
  logic [7:0]  host_wdata_i = 8'h0;
  logic        host_ack_o;
  logic [7:0]  host_rdata_o;
  logic        wr_o, rd_o;
  logic [2:0]  addr_o;
  logic [7:0]  din_o;
  logic [7:0]  dout_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Register block read model: data valid two cycles after rd_o, filler otherwise.
  logic       rd_d1, rd_d2;
  logic [7:0] rb_val = 8'h00;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1 <= 1'b0;
      rd_d2 <= 1'b0;
    end else begin
      rd_d1 <= rd_o;
      rd_d2 <= rd_d1;
    end
  end
  assign dout_i = rd_d2 ? rb_val : 8'h33;

  always #5 clk = ~clk;

  uart_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .div_i(div_i), .lcr_i(lcr_i), .fcr_i(fcr_i),
    .cfg_done_o(cfg_done_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o),
    .tx_req_i(tx_req_i), .tx_data_i(tx_data_i), .tx_ack_o(tx_ack_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
    .wr_o(wr_o), .rd_o(rd_o), .addr_o(addr_o), .din_o(din_o), .dout_i(dout_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Five configuration writes on consecutive cycles, then cfg_done_o on the next one.
  task automatic test_cfg_writes(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3, input logic [7:0] d4);
    logic [2:0] ea [5];
    logic [7:0] ed [5];
    ea[0] = 3'd3; ea[1] = 3'd0; ea[2] = 3'd1; ea[3] = 3'd3; ea[4] = 3'd2;
    ed[0] = d0;   ed[1] = d1;   ed[2] = d2;   ed[3] = d3;   ed[4] = d4;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++;
      if (wr_o !== 1'b1 || rd_o !== 1'b0 || addr_o !== ea[i] || din_o !== ed[i] || cfg_done_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s cfg write %0d: got wr=%b rd=%b addr=%0d din=%h done=%b, want wr=1 rd=0 addr=%0d din=%h done=0",
                 tag, i, wr_o, rd_o, addr_o, din_o, cfg_done_o, ea[i], ed[i]);
      end
    end
    step();
    vec_cnt++;
    if (cfg_done_o !== 1'b1 || wr_o !== 1'b0 || busy_o !== 1'b0 || cfg_err_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s cfg done: got done=%b wr=%b busy=%b err=%b, want done=1 wr=0 busy=0 err=0",
               tag, cfg_done_o, wr_o, busy_o, cfg_err_o);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (wr_o !== 1'b0 || rd_o !== 1'b0 || addr_o !== 3'd0 || din_o !== 8'h00 || cfg_done_o !== 1'b0 ||
        busy_o !== 1'b0 || cfg_err_o !== 1'b0 || tx_ack_o !== 1'b0 || host_ack_o !== 1'b0 || host_rdata_o !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset outputs: got wr=%b rd=%b addr=%0d din=%h done=%b busy=%b err=%b txack=%b hack=%b rdata=%h, want all 0",
               wr_o, rd_o, addr_o, din_o, cfg_done_o, busy_o, cfg_err_o, tx_ack_o, host_ack_o, host_rdata_o);
    end
    rst_n = 1'b1;
    test_cfg_writes("reset_defaults", 8'h83, 8'h08, 8'h01, 8'h03, 8'h07);
  endtask

  task automatic test_arbitration();
    logic exp_tx;
    tx_req_i = 1'b1; tx_data_i = 8'h11;
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 3'd7; host_wdata_i = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_tx = (i % 2) == 0;
      vec_cnt++;
      if (exp_tx) begin
        if (tx_ack_o !== 1'b1 || host_ack_o !== 1'b0 || wr_o !== 1'b1 || addr_o !== 3'd0 || din_o !== 8'h11) begin
          err_cnt++;
          $display("FAIL arb cycle %0d: got txack=%b hack=%b wr=%b addr=%0d din=%h, want TX grant txack=1 hack=0 wr=1 addr=0 din=11",
                   i, tx_ack_o, host_ack_o, wr_o, addr_o, din_o);
        end
      end else begin
        if (tx_ack_o !== 1'b0 || host_ack_o !== 1'b1 || wr_o !== 1'b1 || addr_o !== 3'd7 || din_o !== 8'h5A) begin
          err_cnt++;
          $display("FAIL arb cycle %0d: got txack=%b hack=%b wr=%b addr=%0d din=%h, want HOST grant txack=0 hack=1 wr=1 addr=7 din=5a",
                   i, tx_ack_o, host_ack_o, wr_o, addr_o, din_o);
        end
      end
    end
    tx_req_i = 1'b0; host_req_i = 1'b0;
    step();
    vec_cnt++;
    if (wr_o !== 1'b0 || rd_o !== 1'b0 || tx_ack_o !== 1'b0 || host_ack_o !== 1'b0 || addr_o !== 3'd7 || din_o !== 8'h5A) begin
      err_cnt++;
      $display("FAIL idle hold: got wr=%b rd=%b txack=%b hack=%b addr=%0d din=%h, want wr=0 rd=0 acks=0 addr=7 din=5a",
               wr_o, rd_o, tx_ack_o, host_ack_o, addr_o, din_o);
    end
  endtask

  task automatic test_host_read();
    rb_val = 8'hA5;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 3'd7;
    step();
    vec_cnt++;
    if (rd_o !== 1'b1 || wr_o !== 1'b0 || addr_o !== 3'd7 || host_ack_o !== 1'b0 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL read grant: got rd=%b wr=%b addr=%0d hack=%b busy=%b, want rd=1 wr=0 addr=7 hack=0 busy=1",
               rd_o, wr_o, addr_o, host_ack_o, busy_o);
    end
    tx_req_i = 1'b1; tx_data_i = 8'h22;
    for (int i = 0; i < 2; i++) begin
      step();
      vec_cnt++;
      if (rd_o !== 1'b0 || wr_o !== 1'b0 || addr_o !== 3'd7 || host_ack_o !== 1'b0 || tx_ack_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL read wait %0d: got rd=%b wr=%b addr=%0d hack=%b txack=%b, want rd=0 wr=0 addr=7 hack=0 txack=0",
                 i, rd_o, wr_o, addr_o, host_ack_o, tx_ack_o);
      end
    end
    step();
    vec_cnt++;
    if (host_ack_o !== 1'b1 || host_rdata_o !== 8'hA5 || tx_ack_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL read ack: got hack=%b rdata=%h txack=%b, want hack=1 rdata=a5 txack=0",
               host_ack_o, host_rdata_o, tx_ack_o);
    end
    host_req_i = 1'b0;
    step();
    vec_cnt++;
    if (tx_ack_o !== 1'b1 || wr_o !== 1'b1 || addr_o !== 3'd0 || din_o !== 8'h22 || host_ack_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL tx after read: got txack=%b wr=%b addr=%0d din=%h hack=%b, want txack=1 wr=1 addr=0 din=22 hack=0",
               tx_ack_o, wr_o, addr_o, din_o, host_ack_o);
    end
    tx_req_i = 1'b0;
    step();
    vec_cnt++;
    if (host_rdata_o !== 8'hA5 || tx_ack_o !== 1'b0 || wr_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rdata hold: got rdata=%h txack=%b wr=%b, want rdata=a5 txack=0 wr=0", host_rdata_o, tx_ack_o, wr_o);
    end
  endtask

  task automatic test_host_write_lcr();
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 3'd3; host_wdata_i = 8'h8B;
    step();
    vec_cnt++;
    if (wr_o !== 1'b1 || addr_o !== 3'd3 || din_o !== 8'h0B || host_ack_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL host lcr write: got wr=%b addr=%0d din=%h hack=%b, want wr=1 addr=3 din=0b hack=1",
               wr_o, addr_o, din_o, host_ack_o);
    end
    host_req_i = 1'b0;
    step();
  endtask

  task automatic test_start();
    start_i = 1'b1; div_i = 16'h0A1B; lcr_i = 8'h1F; fcr_i = 8'hC1;
    step();
    start_i = 1'b0;
    vec_cnt++;
    if (cfg_done_o !== 1'b0 || wr_o !== 1'b0 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL start accept: got done=%b wr=%b busy=%b, want done=0 wr=0 busy=1", cfg_done_o, wr_o, busy_o);
    end
    test_cfg_writes("start_seq", 8'h9F, 8'h1B, 8'h0A, 8'h1F, 8'hC1);
  endtask

  task automatic test_reset_mid_sequence();
    start_i = 1'b1; div_i = 16'h0A1B; lcr_i = 8'h1F; fcr_i = 8'hC1;
    step();
    start_i = 1'b0;
    repeat (2) step();
    vec_cnt++;
    if (wr_o !== 1'b1 || addr_o !== 3'd0 || din_o !== 8'h1B) begin
      err_cnt++;
      $display("FAIL pre-abort DLL write: got wr=%b addr=%0d din=%h, want wr=1 addr=0 din=1b", wr_o, addr_o, din_o);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (wr_o !== 1'b0 || rd_o !== 1'b0 || addr_o !== 3'd0 || din_o !== 8'h00 || cfg_done_o !== 1'b0 ||
        busy_o !== 1'b0 || tx_ack_o !== 1'b0 || host_ack_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL async abort: got wr=%b rd=%b addr=%0d din=%h done=%b busy=%b txack=%b hack=%b, want all 0",
               wr_o, rd_o, addr_o, din_o, cfg_done_o, busy_o, tx_ack_o, host_ack_o);
    end
    #1;
    rst_n = 1'b1;
    test_cfg_writes("abort_restart", 8'h83, 8'h08, 8'h01, 8'h03, 8'h07);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_host_read();
    test_host_write_lcr();
    test_start();
    test_reset_mid_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
